adc_serial_reader: RTL and testbench



---
 rtl/adc_serial_reader.sv | 187 ++++++++++++++++++
 tb/tb_adc_serial_reader.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_reader.sv
// rtl/adc_serial_reader.sv - conversion and serial readout controller for a 12-bit SPI-style ADC
//
// Purpose:
//   Starts one conversion on request and pulses adc_convst. It waits for the
//   conversion to finish. It then gates the divider's slow clock onto adc_sck,
//   shifting the channel config word out on adc_sdi and the sample in from
//   adc_sdo. The completed sample and its channel are presented with a
//   one-cycle sample_valid.
//
// Build option:
//   ADC_CONTINUOUS_EN - when defined, each finished readout immediately starts
//   the next conversion on the current ch_sel, without waiting for start.
//
// Ports:
//   clk_in         system clock
//   reset_n        asynchronous active-low reset
//   sclk_div       divided clock level, synchronous to clk_in
//   start          conversion request, honoured only while idle
//   ch_sel         channel for the requested conversion
//   adc_convst     conversion start pulse to the ADC
//   adc_sck        gated serial clock to the ADC
//   adc_sdi        config word to the ADC, MSB first
//   adc_sdo        serial sample from the ADC, MSB first
//   sample_data    last completed sample
//   sample_channel channel of sample_data
//   sample_valid   one-cycle pulse when sample_data/sample_channel update
//   busy           high whenever a conversion is in progress

module adc_serial_reader #(
   parameter int DATA_BITS     = 12,
   parameter int CONVST_CYCLES = 2,
   parameter int CONV_CYCLES   = 80,
   parameter int UNIPOLAR      = 1
) (
   input  logic                 clk_in,
   input  logic                 reset_n,
   input  logic                 sclk_div,
   input  logic                 start,
   input  logic [2:0]           ch_sel,
   output logic                 adc_convst,
   output logic                 adc_sck,
   output logic                 adc_sdi,
   input  logic                 adc_sdo,
   output logic [DATA_BITS-1:0] sample_data,
   output logic [2:0]           sample_channel,
   output logic                 sample_valid,
   output logic                 busy
);

   localparam int CNT_MAX = (CONV_CYCLES > CONVST_CYCLES) ? CONV_CYCLES : CONVST_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BIT_W   = $clog2(DATA_BITS + 1);

   localparam logic [CNT_W-1:0] CONVST_LAST = CNT_W'(CONVST_CYCLES - 1);
   localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(CONV_CYCLES - 1);
   localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_BITS);
   localparam logic             UNI_BIT     = (UNIPOLAR != 0);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CONVST    = 3'd1,
      CONV_WAIT = 3'd2,
      SHIFT     = 3'd3,
      DONE      = 3'd4
   } state_t;

   state_t               state;
   logic                 sclk_q;
   logic [CNT_W-1:0]     cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] tx;
   logic [DATA_BITS-1:0] rx;
   logic [2:0]           ch_q;
   logic                 rise;
   logic                 fall;

   assign rise = sclk_div & ~sclk_q;
   assign fall = ~sclk_div & sclk_q;

   // Config word: start bit, the channel bits in the ADC's odd/sign order
   // (ch0, ch2, ch1), the UNI bit and a sleep bit of 0. The rest are zeros.
   function automatic logic [DATA_BITS-1:0] cfg_word(input logic [2:0] ch);
      cfg_word = {1'b1, ch[0], ch[2], ch[1], UNI_BIT, 1'b0, {(DATA_BITS-6){1'b0}}};
   endfunction

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         sclk_q         <= 1'b0;
         cnt            <= '0;
         bit_cnt        <= '0;
         tx             <= '0;
         rx             <= '0;
         ch_q           <= 3'd0;
         adc_convst     <= 1'b0;
         adc_sck        <= 1'b0;
         adc_sdi        <= 1'b0;
         sample_data    <= '0;
         sample_channel <= 3'd0;
         sample_valid   <= 1'b0;
         busy           <= 1'b0;
      end else begin
         sclk_q       <= sclk_div;
         sample_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  ch_q       <= ch_sel;
                  state      <= CONVST;
                  busy       <= 1'b1;
                  adc_convst <= 1'b1;
                  cnt        <= '0;
                  tx         <= cfg_word(ch_sel);
                  adc_sdi    <= 1'b1;   // MSB of every config word is the start bit
               end
            end

            CONVST: begin
               if (cnt == CONVST_LAST) begin
                  adc_convst <= 1'b0;
                  state      <= CONV_WAIT;
                  cnt        <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            CONV_WAIT: begin
               if (cnt == CONV_LAST) begin
                  state   <= SHIFT;
                  bit_cnt <= '0;
                  adc_sck <= 1'b0;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            SHIFT: begin
               // A pulse always begins on a rise and ends on a fall. An initial
               // fall seen while adc_sck is low is therefore ignored, and a
               // stalled sclk_div simply holds the current level.
               if (rise && !adc_sck) begin
                  adc_sck <= 1'b1;
                  rx      <= {rx[DATA_BITS-2:0], adc_sdo};
                  bit_cnt <= bit_cnt + 1'b1;
               end else if (fall && adc_sck) begin
                  adc_sck <= 1'b0;
                  tx      <= {tx[DATA_BITS-2:0], 1'b0};
                  adc_sdi <= tx[DATA_BITS-2];
                  if (bit_cnt == BIT_LAST) begin
                     state          <= DONE;
                     sample_data    <= rx;
                     sample_channel <= ch_q;
                     sample_valid   <= 1'b1;
                     adc_sdi        <= 1'b0;
                  end
               end
            end

            DONE: begin
`ifdef ADC_CONTINUOUS_EN
               ch_q       <= ch_sel;
               state      <= CONVST;
               adc_convst <= 1'b1;
               cnt        <= '0;
               tx         <= cfg_word(ch_sel);
               adc_sdi    <= 1'b1;
`else
               state <= IDLE;
               busy  <= 1'b0;
`endif
            end

            default: begin
               state      <= IDLE;
               busy       <= 1'b0;
               adc_convst <= 1'b0;
               adc_sck    <= 1'b0;
               adc_sdi    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_serial_reader.sv
// tb/tb_adc_serial_reader.sv - directed self-checking bench for adc_serial_reader

module tb_adc_serial_reader;

   logic        clk_in = 1'b0;
   logic        reset_n = 1'b0;
   logic        sclk_div = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  ch_sel = 3'd0;
   logic        adc_convst;
   logic        adc_sck;
   logic        adc_sdi;
   logic        adc_sdo = 1'b0;
   logic [11:0] sample_data;
   logic [2:0]  sample_channel;
   logic        sample_valid;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // sclk_div control, written only by the main sequence
   bit sclk_run = 1'b0;
   bit sclk_freeze = 1'b0;

   // monitor state, written only by the monitor process
   int  cyc = 0;
   int  sck_total = 0;
   int  convst_hi_total = 0;
   int  valid_total = 0;
   int  convst_fall_cyc = 0;
   int  first_sck_cyc = 0;
   int  sck_since_convst = 0;
   int  idx = 0;
   bit  prev_sck = 1'b0;
   bit  prev_convst = 1'b0;
   bit  sdi_q[$];

   logic [11:0] adc_word = 12'h000;

   adc_serial_reader dut (
      .clk_in         (clk_in),
      .reset_n        (reset_n),
      .sclk_div       (sclk_div),
      .start          (start),
      .ch_sel         (ch_sel),
      .adc_convst     (adc_convst),
      .adc_sck        (adc_sck),
      .adc_sdi        (adc_sdi),
      .adc_sdo        (adc_sdo),
      .sample_data    (sample_data),
      .sample_channel (sample_channel),
      .sample_valid   (sample_valid),
      .busy           (busy)
   );

   always #5 clk_in = ~clk_in;

   // divider model: toggles every clk_in cycle, away from the active edge
   initial begin
      forever begin
         @(negedge clk_in);
         if (sclk_freeze) sclk_div = 1'b0;
         else if (sclk_run) sclk_div = ~sclk_div;
      end
   end

   // bus monitor and ADC model; the ADC presents its MSB after convst and
   // advances one bit on every adc_sck falling edge
   initial begin
      forever begin
         @(negedge clk_in);
         cyc++;
         if (adc_convst) begin
            convst_hi_total++;
            idx = 0;
         end
         if (prev_convst && !adc_convst) begin
            convst_fall_cyc = cyc;
            sck_since_convst = 0;
         end
         if (adc_sck && !prev_sck) begin
            sck_total++;
            sdi_q.push_back(adc_sdi);
            if (sck_since_convst == 0) first_sck_cyc = cyc;
            sck_since_convst++;
         end
         if (!adc_sck && prev_sck) idx++;
         if (sample_valid) valid_total++;
         adc_sdo = (idx < 12) ? adc_word[11 - idx] : 1'b0;
         prev_sck = adc_sck;
         prev_convst = adc_convst;
      end
   end

   task automatic pulse_start(input logic [2:0] ch);
      @(negedge clk_in);
      start = 1'b1;
      ch_sel = ch;
      @(negedge clk_in);
      start = 1'b0;
   endtask

   task automatic wait_valid(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk_in);
         if (sample_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic sdi_word(input int base, output logic [11:0] w);
      w = 12'h000;
      for (int i = 0; i < 12; i++) w = {w[10:0], logic'(sdi_q[base + i])};
   endtask

   task automatic test_reset();
      int sck0, cv0;
      reset_n = 1'b0;
      sclk_run = 1'b1;
      repeat (6) @(negedge clk_in);
      checks++;
      if ({adc_convst, adc_sck, adc_sdi, sample_valid, busy} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: convst/sck/sdi/valid/busy=%b required 00000",
                  {adc_convst, adc_sck, adc_sdi, sample_valid, busy});
      end
      checks++;
      if (sample_data !== 12'h000 || sample_channel !== 3'd0) begin
         errors++;
         $display("FAIL reset_sample: data=%h ch=%0d required 000/0", sample_data, sample_channel);
      end
      reset_n = 1'b1;
      sck0 = sck_total;
      cv0 = convst_hi_total;
      repeat (30) @(negedge clk_in);
      checks++;
      if (sck_total != sck0 || cv0 != convst_hi_total || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: sck pulses=%0d convst cycles=%0d busy=%b required 0/0/0",
                  sck_total - sck0, convst_hi_total - cv0, busy);
      end
   endtask

   task automatic test_single();
      int sck0, cv0, v0, sb;
      bit ok;
      logic [11:0] w;
      adc_word = 12'hA5C;
      sck0 = sck_total; cv0 = convst_hi_total; v0 = valid_total; sb = sdi_q.size();
      pulse_start(3'd5);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL single_busy_rise: busy=%b required 1", busy);
      end
      wait_valid(400, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_timeout: sample_valid=0 required 1 within 400 cycles");
      end
      checks++;
      if (sample_data !== 12'hA5C || sample_channel !== 3'd5) begin
         errors++;
         $display("FAIL single_sample: data=%h ch=%0d required a5c/5", sample_data, sample_channel);
      end
      checks++;
      if (convst_hi_total - cv0 != 2) begin
         errors++;
         $display("FAIL single_convst_len: %0d cycles required 2", convst_hi_total - cv0);
      end
      checks++;
      if (first_sck_cyc - convst_fall_cyc < 81 || first_sck_cyc - convst_fall_cyc > 82) begin
         errors++;
         $display("FAIL single_conv_wait: %0d cycles required 81..82",
                  first_sck_cyc - convst_fall_cyc);
      end
      checks++;
      if (sck_total - sck0 != 12) begin
         errors++;
         $display("FAIL single_sck_count: %0d pulses required 12", sck_total - sck0);
      end
      sdi_word(sb, w);
      checks++;
      if (w !== 12'hE80) begin
         errors++;
         $display("FAIL single_sdi: %b required 111010000000", w);
      end
      @(negedge clk_in);
      checks++;
      if (busy !== 1'b0 || sample_valid !== 1'b0 || valid_total - v0 != 1) begin
         errors++;
         $display("FAIL single_done: busy=%b valid=%b pulses=%0d required 0/0/1",
                  busy, sample_valid, valid_total - v0);
      end
      checks++;
      if (adc_sdi !== 1'b0 || adc_sck !== 1'b0) begin
         errors++;
         $display("FAIL single_idle_pins: sdi=%b sck=%b required 0/0", adc_sdi, adc_sck);
      end
   endtask

   task automatic test_busy_reject();
      int v0, cv0, sb;
      bit ok;
      logic [11:0] w;
      adc_word = 12'h3C7;
      v0 = valid_total; cv0 = convst_hi_total; sb = sdi_q.size();
      pulse_start(3'd2);
      repeat (20) @(negedge clk_in);
      pulse_start(3'd7);
      wait_valid(400, ok);
      repeat (200) @(negedge clk_in);
      checks++;
      if (!ok || valid_total - v0 != 1 || convst_hi_total - cv0 != 2) begin
         errors++;
         $display("FAIL busy_reject_count: pulses=%0d convst cycles=%0d required 1/2",
                  valid_total - v0, convst_hi_total - cv0);
      end
      checks++;
      if (sample_channel !== 3'd2 || sample_data !== 12'h3C7) begin
         errors++;
         $display("FAIL busy_reject_sample: ch=%0d data=%h required 2/3c7", sample_channel, sample_data);
      end
      sdi_word(sb, w);
      checks++;
      if (w !== 12'h980) begin
         errors++;
         $display("FAIL busy_reject_sdi: %b required 100110000000", w);
      end
   endtask

   task automatic test_reset_mid_shift();
      int sck0, v0, sb;
      bit ok;
      logic [11:0] w;
      adc_word = 12'h5A5;
      sck0 = sck_total;
      pulse_start(3'd6);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_in);
         if (sck_total - sck0 == 6 && adc_sck == 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok || busy !== 1'b1) begin
         errors++;
         $display("FAIL midshift_reach: reached=%0d busy=%b required 1/1", ok, busy);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({adc_convst, adc_sck, adc_sdi, sample_valid, busy} !== 5'b0 ||
          sample_data !== 12'h000 || sample_channel !== 3'd0) begin
         errors++;
         $display("FAIL midshift_async_clear: pins=%b data=%h ch=%0d required 00000/000/0",
                  {adc_convst, adc_sck, adc_sdi, sample_valid, busy}, sample_data, sample_channel);
      end
      v0 = valid_total;
      repeat (3) @(negedge clk_in);
      reset_n = 1'b1;
      repeat (150) @(negedge clk_in);
      checks++;
      if (valid_total != v0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midshift_no_valid: pulses=%0d busy=%b required 0/0", valid_total - v0, busy);
      end
      adc_word = 12'h001;
      sb = sdi_q.size();
      pulse_start(3'd1);
      wait_valid(400, ok);
      checks++;
      if (!ok || sample_data !== 12'h001 || sample_channel !== 3'd1) begin
         errors++;
         $display("FAIL midshift_recover: seen=%0d data=%h ch=%0d required 1/001/1",
                  ok, sample_data, sample_channel);
      end
      sdi_word(sb, w);
      checks++;
      if (w !== 12'hC80) begin
         errors++;
         $display("FAIL midshift_sdi: %b required 110010000000", w);
      end
      repeat (3) @(negedge clk_in);
   endtask

   task automatic test_stall();
      int sck0, sck_frz;
      bit ok, sck_bad, busy_bad, moved;
      adc_word = 12'h9B3;
      sck0 = sck_total;
      pulse_start(3'd4);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_in);
         if (sck_total - sck0 == 5 && adc_sck == 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      sclk_freeze = 1'b1;
      repeat (4) @(negedge clk_in);
      sck_frz = sck_total;
      sck_bad = 1'b0;
      busy_bad = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_in);
         if (adc_sck !== 1'b0) sck_bad = 1'b1;
         if (busy !== 1'b1) busy_bad = 1'b1;
      end
      moved = (sck_total != sck_frz);
      checks++;
      if (!ok || sck_bad || moved) begin
         errors++;
         $display("FAIL stall_sck: reached=%0d sck_high=%0d new_pulses=%0d required 1/0/0",
                  ok, sck_bad, moved);
      end
      checks++;
      if (busy_bad) begin
         errors++;
         $display("FAIL stall_busy: busy dropped while frozen, required 1");
      end
      sclk_freeze = 1'b0;
      wait_valid(400, ok);
      checks++;
      if (!ok || sck_total - sck0 != 12 || sample_data !== 12'h9B3 || sample_channel !== 3'd4) begin
         errors++;
         $display("FAIL stall_resume: seen=%0d pulses=%0d data=%h ch=%0d required 1/12/9b3/4",
                  ok, sck_total - sck0, sample_data, sample_channel);
      end
      repeat (3) @(negedge clk_in);
   endtask

`ifdef ADC_CONTINUOUS_EN
   task automatic test_continuous();
      bit ok;
      adc_word = 12'h123;
      pulse_start(3'd3);
      repeat (10) @(negedge clk_in);
      ch_sel = 3'd4;
      wait_valid(400, ok);
      checks++;
      if (!ok || sample_channel !== 3'd3 || sample_data !== 12'h123) begin
         errors++;
         $display("FAIL cont_first: seen=%0d ch=%0d data=%h required 1/3/123", ok, sample_channel, sample_data);
      end
      @(negedge clk_in);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL cont_busy: busy=%b required 1", busy);
      end
      wait_valid(400, ok);
      checks++;
      if (!ok || sample_channel !== 3'd4 || sample_data !== 12'h123) begin
         errors++;
         $display("FAIL cont_second: seen=%0d ch=%0d data=%h required 1/4/123", ok, sample_channel, sample_data);
      end
   endtask
`else
   task automatic test_single_shot();
      int v0;
      v0 = valid_total;
      repeat (300) @(negedge clk_in);
      checks++;
      if (valid_total != v0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_shot_idle: extra pulses=%0d busy=%b required 0/0", valid_total - v0, busy);
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef ADC_CONTINUOUS_EN
      test_continuous();
`else
      test_single();
      test_single_shot();
      test_busy_reject();
      test_reset_mid_shift();
      test_stall();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
